// File: rtl/parameterized_johnson_monitor.sv
// Johnson-counter monitor: decodes each sampled code to its index, checks
// that the counter only holds or steps by +1, tracks lock, and counts faults.
module parameterized_johnson_monitor #(
    parameter int  WIDTH      = 4,
    parameter int  LOCK_COUNT = 3,
    localparam int IDX_W      = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] code,
    input  logic             clear_err,
    output logic [IDX_W-1:0] idx_out,
    output logic             idx_valid,
    output logic             illegal,
    output logic             step_err,
    output logic             locked,
    output logic [15:0]      err_count
);

    localparam int               NSTATES = 2*WIDTH;
    localparam int               GOOD_W  = $clog2(LOCK_COUNT+1);
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(NSTATES-1);

    typedef enum logic [1:0] {ST_SEARCH, ST_TRACK, ST_LOCKED} state_t;

    state_t            state_reg;
    logic [IDX_W-1:0]  prev_reg;
    logic [GOOD_W-1:0] good_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              idx_valid_reg;
    logic              illegal_reg;
    logic              step_err_reg;
    logic              locked_reg;
    logic [15:0]       err_count_reg;

    logic [NSTATES-1:0] match_vec;
    logic               legal;
    logic [IDX_W-1:0]   dec_idx;
    logic [IDX_W-1:0]   prev_next;
    logic               is_hold;
    logic               is_adv;
    logic               step_cond;
    logic               err_event;

    // One comparator per legal code: indices 0..WIDTH fill ones from the MSB,
    // the rest drain ones towards the LSB.
    generate
        for (genvar gi = 0; gi < NSTATES; gi++) begin : gen_pat
            localparam logic [WIDTH-1:0] PAT = (gi <= WIDTH)
                ? ~({WIDTH{1'b1}} >> gi)
                :  ({WIDTH{1'b1}} >> (gi - WIDTH));
            assign match_vec[gi] = (code == PAT);
        end
    endgenerate

    // Patterns are distinct, so at most one match bit is set; encode it.
    always_comb begin
        dec_idx = '0;
        for (int i = 0; i < NSTATES; i++) begin
            if (match_vec[i]) dec_idx = IDX_W'(i);
        end
    end

    assign legal     = |match_vec;
    assign prev_next = (prev_reg == LAST) ? '0 : prev_reg + IDX_W'(1);
    assign is_hold   = (dec_idx == prev_reg);
    assign is_adv    = (dec_idx == prev_next);
    assign step_cond = in_valid && legal && (state_reg != ST_SEARCH) && !is_hold && !is_adv;
    assign err_event = (in_valid && !legal) || step_cond;

    // Lock FSM with registered index/pulse/lock outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_SEARCH;
            prev_reg      <= '0;
            good_reg      <= '0;
            idx_reg       <= '0;
            idx_valid_reg <= 1'b0;
            illegal_reg   <= 1'b0;
            step_err_reg  <= 1'b0;
            locked_reg    <= 1'b0;
        end else begin
            idx_valid_reg <= 1'b0;
            illegal_reg   <= 1'b0;
            step_err_reg  <= 1'b0;
            if (in_valid) begin
                if (!legal) begin
                    illegal_reg <= 1'b1;
                    state_reg   <= ST_SEARCH;
                    locked_reg  <= 1'b0;
                end else begin
                    idx_reg       <= dec_idx;
                    idx_valid_reg <= 1'b1;
                    prev_reg      <= dec_idx;
                    if (state_reg == ST_SEARCH) begin
                        state_reg  <= ST_TRACK;
                        good_reg   <= '0;
                        locked_reg <= 1'b0;
                    end else if (is_hold) begin
                        // counter paused: nothing to learn
                    end else if (is_adv) begin
                        if (state_reg == ST_TRACK) begin
                            good_reg <= good_reg + GOOD_W'(1);
                            if (good_reg + GOOD_W'(1) == GOOD_W'(LOCK_COUNT)) begin
                                state_reg  <= ST_LOCKED;
                                locked_reg <= 1'b1;
                            end
                        end
                    end else begin
                        step_err_reg <= 1'b1;
                        state_reg    <= ST_TRACK;
                        good_reg     <= '0;
                        locked_reg   <= 1'b0;
                    end
                end
            end
        end
    end

    // Saturating fault counter; a clear coinciding with a fault leaves one.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_reg <= '0;
        end else if (clear_err) begin
            err_count_reg <= err_event ? 16'd1 : 16'd0;
        end else if (err_event && (err_count_reg != 16'hFFFF)) begin
            err_count_reg <= err_count_reg + 16'd1;
        end
    end

    assign idx_out   = idx_reg;
    assign idx_valid = idx_valid_reg;
    assign illegal   = illegal_reg;
    assign step_err  = step_err_reg;
    assign locked    = locked_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_parameterized_johnson_monitor.sv
// Scoreboard bench for the Johnson monitor (WIDTH=4, LOCK_COUNT=3):
// directed samples push hand-computed responses, a monitor pops and compares.
module tb_parameterized_johnson_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b1;
    logic [3:0]  code = 4'b1010;
    logic        clear_err = 1'b0;
    logic [2:0]  idx_out;
    logic        idx_valid;
    logic        illegal;
    logic        step_err;
    logic        locked;
    logic [15:0] err_count;

    typedef struct packed {
        logic [2:0]  idx;
        logic        iv;
        logic        ill;
        logic        se;
        logic        lk;
        logic [15:0] ec;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    bit   verbose = 1'b1;

    parameterized_johnson_monitor #(.WIDTH(4), .LOCK_COUNT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .code      (code),
        .clear_err (clear_err),
        .idx_out   (idx_out),
        .idx_valid (idx_valid),
        .illegal   (illegal),
        .step_err  (step_err),
        .locked    (locked),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Drive one sample before the next rising edge and queue its response.
    task automatic step(input logic r, input logic v, input logic [3:0] c,
                        input logic clr, input logic [2:0] idx, input logic iv,
                        input logic ill, input logic se, input logic lk,
                        input logic [15:0] ec);
        exp_t e;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        code      = c;
        clear_err = clr;
        e.idx = idx; e.iv = iv; e.ill = ill; e.se = se; e.lk = lk; e.ec = ec;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle, one cycle after each sample.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (idx_out !== e.idx || idx_valid !== e.iv || illegal !== e.ill ||
                    step_err !== e.se || locked !== e.lk || err_count !== e.ec) begin
                    errors++;
                    $display("FAIL txn %0d: got idx=%0d iv=%b ill=%b se=%b lk=%b ec=%h, want idx=%0d iv=%b ill=%b se=%b lk=%b ec=%h",
                             checks, idx_out, idx_valid, illegal, step_err, locked, err_count,
                             e.idx, e.iv, e.ill, e.se, e.lk, e.ec);
                end else if (verbose) begin
                    $display("ok   txn %0d: idx=%0d iv=%b ill=%b se=%b lk=%b ec=%h",
                             checks, idx_out, idx_valid, illegal, step_err, locked, err_count);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        //    rst v  code   clr idx iv ill se lk ec
        // reset dominates a valid illegal sample
        step(1, 1, 4'b1010, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 4'b1010, 1, 0, 0, 0, 0, 0, 0);
        // lock-in
        step(0, 1, 4'b0000, 0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 4'b1000, 0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 4'b1100, 0, 2, 1, 0, 0, 0, 0);
        step(0, 1, 4'b1110, 0, 3, 1, 0, 0, 1, 0);
        step(0, 0, 4'b0101, 0, 3, 0, 0, 0, 1, 0);   // gap: garbage ignored
        // run round, hold, wrap
        step(0, 1, 4'b1111, 0, 4, 1, 0, 0, 1, 0);
        step(0, 1, 4'b0111, 0, 5, 1, 0, 0, 1, 0);
        step(0, 1, 4'b0011, 0, 6, 1, 0, 0, 1, 0);
        step(0, 1, 4'b0001, 0, 7, 1, 0, 0, 1, 0);
        step(0, 1, 4'b0001, 0, 7, 1, 0, 0, 1, 0);
        step(0, 1, 4'b0000, 0, 0, 1, 0, 0, 1, 0);
        // illegal while locked
        step(0, 1, 4'b1010, 0, 0, 0, 1, 0, 0, 1);
        step(0, 1, 4'b1000, 0, 1, 1, 0, 0, 0, 1);
        step(0, 1, 4'b1100, 0, 2, 1, 0, 0, 0, 1);
        step(0, 1, 4'b1110, 0, 3, 1, 0, 0, 0, 1);
        step(0, 1, 4'b1111, 0, 4, 1, 0, 0, 1, 1);
        step(0, 1, 4'b0111, 0, 5, 1, 0, 0, 1, 1);
        step(0, 1, 4'b0011, 0, 6, 1, 0, 0, 1, 1);
        step(0, 1, 4'b0001, 0, 7, 1, 0, 0, 1, 1);
        step(0, 1, 4'b0000, 0, 0, 1, 0, 0, 1, 1);
        step(0, 1, 4'b1000, 0, 1, 1, 0, 0, 1, 1);
        step(0, 1, 4'b1100, 0, 2, 1, 0, 0, 1, 1);
        // skip 2 -> 4, then relock
        step(0, 1, 4'b1111, 0, 4, 1, 0, 1, 0, 2);
        step(0, 0, 4'b0000, 0, 4, 0, 0, 0, 0, 2);   // gap keeps good count
        step(0, 1, 4'b0111, 0, 5, 1, 0, 0, 0, 2);
        step(0, 1, 4'b0011, 0, 6, 1, 0, 0, 0, 2);
        step(0, 1, 4'b0001, 0, 7, 1, 0, 0, 1, 2);
        step(0, 0, 4'b1010, 0, 7, 0, 0, 0, 1, 2);
        // clear together with an illegal sample, then clear alone
        step(0, 1, 4'b1010, 1, 7, 0, 1, 0, 0, 1);
        step(0, 0, 4'b1010, 1, 7, 0, 0, 0, 0, 0);
        // saturation: 65536 illegal samples
        verbose = 1'b0;
        for (int k = 1; k <= 65536; k++) begin
            step(0, 1, 4'b1010, 0, 7, 0, 1, 0, 0, (k > 65535) ? 16'hFFFF : 16'(k));
        end
        verbose = 1'b1;
        step(0, 1, 4'b1011, 0, 7, 0, 1, 0, 0, 16'hFFFF);
        step(0, 1, 4'b0000, 0, 0, 1, 0, 0, 0, 16'hFFFF);
        step(0, 1, 4'b1000, 0, 1, 1, 0, 0, 0, 16'hFFFF);
        // mid-sequence reset discards history; first sample is a fresh search
        step(1, 1, 4'b1100, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 4'b0011, 0, 6, 1, 0, 0, 0, 0);
        step(0, 1, 4'b0001, 0, 7, 1, 0, 0, 0, 0);
        step(0, 1, 4'b1000, 0, 1, 1, 0, 1, 0, 1);
        // drain the scoreboard with a bounded wait
        @(negedge clk);
        in_valid  = 1'b0;
        clear_err = 1'b0;
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parameterized_johnson_monitor.md
PARAMETERIZED_JOHNSON_MONITOR -- requirements
Module: parameterized_johnson_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, Johnson code width; legal range >= 2.
REQ-002 SHALL have parameter LOCK_COUNT, default 3, consecutive +1 advances required to declare lock; legal range >= 1.
REQ-003 SHALL derive IDX_W = $clog2(2*WIDTH), the width of the decoded index.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk, rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  code is sampled on this cycle.
REQ-008 code  input  WIDTH  Johnson code from the counter being monitored.
REQ-009 clear_err  input  1  synchronous clear of err_count.
REQ-010 idx_out  output  IDX_W  decoded index, 0..2*WIDTH-1.
REQ-011 idx_valid  output  1  one-cycle pulse: idx_out updated from a legal code.
REQ-012 illegal  output  1  one-cycle pulse: sampled code not a legal Johnson state.
REQ-013 step_err  output  1  one-cycle pulse: legal code, but not a hold and not a +1 advance.
REQ-014 locked  output  1  level: monitor is in state LOCKED.
REQ-015 err_count  output  16  saturating count of illegal plus step_err events.

Function
REQ-016 Legal codes SHALL be exactly 2*WIDTH: contiguous ones MSB-aligned (incl. all-zero and all-ones), or contiguous ones LSB-aligned with MSB=0.
REQ-017 Decode SHALL be: MSB=1 with k ones -> index k; MSB=0 with n ones -> index 0 if n=0, else 2*WIDTH-n. The sequence 0000,1000,1100,1110,1111,0111,0011,0001 (WIDTH=4) decodes to 0..7.
REQ-018 All outputs SHALL be registered; a sample with in_valid=1 SHALL be reflected on the outputs exactly 1 cycle later.
REQ-019 On a cycle with in_valid=0: idx_valid, illegal, step_err SHALL be 0 the next cycle; idx_out, FSM state, the previous-index register and the good-step counter SHALL hold.
REQ-020 On an illegal sample: illegal=1, idx_valid=0, idx_out holds, FSM -> SEARCH.
REQ-021 FSM states SHALL be SEARCH, TRACK, LOCKED; the state register holds prev index and a good-step counter (0..LOCK_COUNT).
REQ-022 SEARCH: legal sample -> TRACK, prev=index, good=0, no step_err.
REQ-023 TRACK/LOCKED: a legal sample equal to prev is a hold: no error, good unchanged, state unchanged.
REQ-024 TRACK/LOCKED: legal sample = (prev+1) mod 2*WIDTH is an advance; wrap from 2*WIDTH-1 to 0 is an advance.
REQ-025 TRACK advance: good+1; if good+1 = LOCK_COUNT -> LOCKED, else stay TRACK.
REQ-026 TRACK/LOCKED: any other legal sample -> step_err=1, idx_valid=1, state -> TRACK, good=0, prev=new index.
REQ-027 prev SHALL update to the decoded index on every legal sample.
REQ-028 locked SHALL be 1 iff state is LOCKED; it drops the cycle an illegal or step_err is reported.
REQ-029 err_count SHALL increment by 1 on each cycle where illegal or step_err is asserted, and saturate at 16'hFFFF.
REQ-030 clear_err SHALL zero err_count; simultaneous clear_err and error event SHALL yield err_count=1.

Reset
REQ-031 rst=1 at a clock edge SHALL force: state SEARCH, prev=0, good=0, idx_out=0, idx_valid=0, illegal=0, step_err=0, locked=0, err_count=0; rst overrides in_valid and clear_err.
REQ-032 rst mid-sequence SHALL discard lock and history; the first sample after reset is treated as in SEARCH.

Verification (WIDTH=4, LOCK_COUNT=3)
REQ-033 Reset: hold rst 2 cycles with in_valid=1, code=1010 -> all outputs 0, err_count=0.
REQ-034 Lock-in: samples 0000,1000,1100,1110 on consecutive cycles -> idx_out 0,1,2,3 with idx_valid each 1 cycle later; locked=1 in the cycle idx_out=3 appears, no step_err.
REQ-035 Wrap and hold: locked, samples 0011,0001,0001,0000 -> idx 6,7,7,0, no errors, locked stays 1.
REQ-036 Illegal: locked, sample 1010 -> illegal=1, idx_valid=0, idx_out held, locked=0, err_count+1; next 1000 -> TRACK, no step_err.
REQ-037 Skip: locked at idx 2 (1100), sample 1111 -> step_err=1, idx_out=4, locked=0, err_count+1; then 0111,0011,0001 -> locked=1 again.
REQ-038 Counter: clear_err together with illegal sample -> err_count=1; force 65536 errors -> err_count stays 16'hFFFF; in_valid gaps between samples change no state.
